countdown_core: RTL and testbench

Kitchen-timer countdown engine sitting directly downstream of the one-second tick divider. It consumes the divider's single-cycle `tick` pulse, keeps a BCD MM:SS count, and runs the IDLE/RUN/PAUSE/ALARM control. It drives the divider's enable through `run_en` and feeds the display and buzzer stages.

---
 rtl/kt_pkg.sv | 28 ++
 rtl/countdown_core_if.sv | 28 ++
 rtl/bcd_digit_dec.sv | 28 ++
 rtl/countdown_core.sv | 135 +++++++++++++
 tb/tb_countdown_core.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/kt_pkg.sv
// Shared kitchen-timer definitions: FSM state encoding, BCD digit limits and
// the preset validity check used wherever a BCD MM:SS value is accepted.
// No logic, no latency; purely declarations and a pure function.
package kt_pkg;

  // state_o encoding as seen by the display stage
  localparam logic [1:0] STATE_O_IDLE  = 2'd0;
  localparam logic [1:0] STATE_O_RUN   = 2'd1;
  localparam logic [1:0] STATE_O_PAUSE = 2'd2;
  localparam logic [1:0] STATE_O_ALARM = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = STATE_O_IDLE,
    ST_RUN   = STATE_O_RUN,
    ST_PAUSE = STATE_O_PAUSE,
    ST_ALARM = STATE_O_ALARM
  } state_e;

  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [3:0] BCD_FIVE = 4'd5;

  // MM 00..99, SS 00..59, every nibble a legal BCD digit
  function automatic logic preset_valid(input logic [7:0] mm, input logic [7:0] ss);
    return (mm[7:4] <= BCD_NINE) && (mm[3:0] <= BCD_NINE) &&
           (ss[7:4] <= BCD_FIVE) && (ss[3:0] <= BCD_NINE);
  endfunction

endpackage

// File: rtl/countdown_core_if.sv
// Control and status bundle between the timer engine and its neighbours
// (tick divider, buttons, display, buzzer). master = environment, slave = core.
// Ports: tick/load/preset_min/preset_sec/start_stop/clear in; run_en, time_*, state_o, alarm, alarm_blink, load_err out.
interface countdown_core_if;
  logic       tick;
  logic       load;
  logic [7:0] preset_min;
  logic [7:0] preset_sec;
  logic       start_stop;
  logic       clear;
  logic       run_en;
  logic [7:0] time_min;
  logic [7:0] time_sec;
  logic [1:0] state_o;
  logic       alarm;
  logic       alarm_blink;
  logic       load_err;

  modport master (
    output tick, load, preset_min, preset_sec, start_stop, clear,
    input  run_en, time_min, time_sec, state_o, alarm, alarm_blink, load_err
  );

  modport slave (
    input  tick, load, preset_min, preset_sec, start_stop, clear,
    output run_en, time_min, time_sec, state_o, alarm, alarm_blink, load_err
  );
endinterface

// File: rtl/bcd_digit_dec.sv
// Decrement one BCD digit when borrow_in is set, wrapping 0 -> WRAP with borrow_out.
// Latency: combinational. No flow control.
// Ports: digit_in, borrow_in in; digit_out, borrow_out out.
module bcd_digit_dec
  import kt_pkg::*;
#(
  parameter logic [3:0] WRAP = BCD_NINE
) (
  input  logic [3:0] digit_in,
  input  logic       borrow_in,
  output logic [3:0] digit_out,
  output logic       borrow_out
);

  always_comb begin
    digit_out  = digit_in;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit_in == 4'd0) begin
        digit_out  = WRAP;
        borrow_out = 1'b1;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end
  end

endmodule

// File: rtl/countdown_core.sv
// Kitchen-timer engine: BCD MM:SS countdown with IDLE/RUN/PAUSE/ALARM control.
// Latency: every output registered, events act on the edge they are sampled.
// No backpressure: single-cycle pulses in, one event per pulse per edge.
// Ports: clk_in, reset (async, active-high), bus (countdown_core_if.slave).
module countdown_core
  import kt_pkg::*;
#(
  parameter int ALARM_TICKS = 30
) (
  input  logic                   clk_in,
  input  logic                   reset,
  countdown_core_if.slave        bus
);

  state_e     state;
  logic [7:0] cnt_min, cnt_sec;
  logic [7:0] dec_min, dec_sec;
  logic [7:0] alarm_cnt;
  logic       run_en, alarm, alarm_blink, load_err;
  logic       b_sec_ones, b_sec_tens, b_min_ones;
  logic       underflow;   // count was 00:00; the decrement must not be applied
  logic       cnt_zero, dec_zero, preset_ok, preset_zero;

  // One-second decrement chain, least significant digit first
  bcd_digit_dec #(.WRAP(BCD_NINE)) u_sec_ones (
    .digit_in(cnt_sec[3:0]), .borrow_in(1'b1),
    .digit_out(dec_sec[3:0]), .borrow_out(b_sec_ones));
  bcd_digit_dec #(.WRAP(BCD_FIVE)) u_sec_tens (
    .digit_in(cnt_sec[7:4]), .borrow_in(b_sec_ones),
    .digit_out(dec_sec[7:4]), .borrow_out(b_sec_tens));
  bcd_digit_dec #(.WRAP(BCD_NINE)) u_min_ones (
    .digit_in(cnt_min[3:0]), .borrow_in(b_sec_tens),
    .digit_out(dec_min[3:0]), .borrow_out(b_min_ones));
  bcd_digit_dec #(.WRAP(BCD_NINE)) u_min_tens (
    .digit_in(cnt_min[7:4]), .borrow_in(b_min_ones),
    .digit_out(dec_min[7:4]), .borrow_out(underflow));

  assign cnt_zero    = ({cnt_min, cnt_sec} == 16'h0000);
  assign dec_zero    = ({dec_min, dec_sec} == 16'h0000);
  assign preset_ok   = preset_valid(bus.preset_min, bus.preset_sec);
  assign preset_zero = ({bus.preset_min, bus.preset_sec} == 16'h0000);

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt_min     <= 8'h00;
      cnt_sec     <= 8'h00;
      alarm_cnt   <= 8'd0;
      run_en      <= 1'b0;
      alarm       <= 1'b0;
      alarm_blink <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      load_err <= 1'b0;
      if (bus.clear) begin
        state       <= ST_IDLE;
        cnt_min     <= 8'h00;
        cnt_sec     <= 8'h00;
        alarm_cnt   <= 8'd0;
        run_en      <= 1'b0;
        alarm       <= 1'b0;
        alarm_blink <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            // a load (valid or not) takes the cycle; start_stop waits
            if (bus.load) begin
              if (preset_ok) begin
                cnt_min <= bus.preset_min;
                cnt_sec <= bus.preset_sec;
              end else begin
                load_err <= 1'b1;
              end
            end else if (bus.start_stop && !cnt_zero) begin
              state  <= ST_RUN;
              run_en <= 1'b1;
            end
          end
          ST_RUN: begin
            if (bus.tick && !underflow) begin
              cnt_min <= dec_min;
              cnt_sec <= dec_sec;
            end
            // reaching 00:00 beats a simultaneous pause request
            if (bus.tick && !underflow && dec_zero) begin
              state       <= ST_ALARM;
              run_en      <= 1'b0;
              alarm       <= 1'b1;
              alarm_cnt   <= 8'd0;
              alarm_blink <= 1'b0;
            end else if (bus.start_stop) begin
              state  <= ST_PAUSE;
              run_en <= 1'b0;
            end
          end
          ST_PAUSE: begin
            if (bus.load) begin
              if (preset_ok) begin
                cnt_min <= bus.preset_min;
                cnt_sec <= bus.preset_sec;
                if (preset_zero) state <= ST_IDLE;
              end else begin
                load_err <= 1'b1;
              end
            end else if (bus.start_stop) begin
              state  <= ST_RUN;
              run_en <= 1'b1;
            end
          end
          ST_ALARM: begin
            if (bus.start_stop || (bus.tick && alarm_cnt == 8'(ALARM_TICKS - 1))) begin
              state       <= ST_IDLE;
              alarm       <= 1'b0;
              alarm_blink <= 1'b0;
              alarm_cnt   <= 8'd0;
            end else if (bus.tick) begin
              alarm_cnt   <= alarm_cnt + 8'd1;
              alarm_blink <= ~alarm_blink;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.run_en      = run_en;
  assign bus.time_min    = cnt_min;
  assign bus.time_sec    = cnt_sec;
  assign bus.state_o     = state;
  assign bus.alarm       = alarm;
  assign bus.alarm_blink = alarm_blink;
  assign bus.load_err    = load_err;

endmodule

// File: tb/tb_countdown_core.sv
// Self-checking bench for countdown_core: directed scenarios plus random
// events, compared each cycle against a seconds-based reference model.
module tb_countdown_core;

  localparam int AT = 30;

  logic clk_in = 1'b0;
  logic reset;
  countdown_core_if bus();

  countdown_core #(.ALARM_TICKS(AT)) dut (
    .clk_in(clk_in),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: remaining time as plain seconds, state as 0..3
  int m_st, m_t, m_acnt;
  bit m_blink, m_lerr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int t);
    int mm, ss;
    mm = t / 60;
    ss = t % 60;
    return 16'(((mm / 10) * 16 + mm % 10) * 256 + (ss / 10) * 16 + ss % 10);
  endfunction

  function automatic bit pre_ok(input logic [7:0] pm, input logic [7:0] ps);
    return (int'(pm) / 16 <= 9) && (int'(pm) % 16 <= 9) &&
           (int'(ps) / 16 <= 5) && (int'(ps) % 16 <= 9);
  endfunction

  function automatic int pre_secs(input logic [7:0] pm, input logic [7:0] ps);
    return ((int'(pm) / 16) * 10 + int'(pm) % 16) * 60 + (int'(ps) / 16) * 10 + int'(ps) % 16;
  endfunction

  task automatic model_reset();
    m_st = 0; m_t = 0; m_acnt = 0; m_blink = 0; m_lerr = 0;
  endtask

  task automatic model_edge(input bit tk, input bit ld, input logic [7:0] pm,
                            input logic [7:0] ps, input bit ss, input bit cl);
    m_lerr = 0;
    if (cl) begin
      m_st = 0; m_t = 0; m_acnt = 0; m_blink = 0;
    end else if (m_st == 0) begin
      if (ld) begin
        if (pre_ok(pm, ps)) m_t = pre_secs(pm, ps);
        else m_lerr = 1;
      end else if (ss && m_t != 0) m_st = 1;
    end else if (m_st == 1) begin
      if (tk && m_t > 0) begin
        m_t--;
        if (m_t == 0) begin m_st = 3; m_acnt = 0; m_blink = 0; end
        else if (ss) m_st = 2;
      end else if (ss) m_st = 2;
    end else if (m_st == 2) begin
      if (ld) begin
        if (pre_ok(pm, ps)) begin
          m_t = pre_secs(pm, ps);
          if (m_t == 0) m_st = 0;
        end else m_lerr = 1;
      end else if (ss) m_st = 1;
    end else begin
      if (ss) begin
        m_st = 0; m_acnt = 0; m_blink = 0;
      end else if (tk) begin
        m_acnt++;
        if (m_acnt == AT) begin m_st = 0; m_acnt = 0; m_blink = 0; end
        else m_blink = ~m_blink;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_time"}, 32'({bus.time_min, bus.time_sec}), 32'(to_bcd(m_t)));
    chk({tag, "_state"}, 32'(bus.state_o), 32'(m_st));
    chk({tag, "_flags"}, 32'({bus.run_en, bus.alarm, bus.alarm_blink, bus.load_err}),
        32'({m_st == 1, m_st == 3, m_blink, m_lerr}));
  endtask

  // inputs applied at negedge, sampled by the posedge, outputs checked at the next negedge
  task automatic step(input string tag, input bit tk, input bit ld, input logic [7:0] pm,
                      input logic [7:0] ps, input bit ss, input bit cl);
    bus.tick = tk; bus.load = ld; bus.preset_min = pm; bus.preset_sec = ps;
    bus.start_stop = ss; bus.clear = cl;
    @(posedge clk_in);
    model_edge(tk, ld, pm, ps, ss, cl);
    @(negedge clk_in);
    bus.tick = 0; bus.load = 0; bus.start_stop = 0; bus.clear = 0;
    check_outputs(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1, 0, 8'h00, 8'h00, 0, 0);
  endtask

  initial begin
    bus.tick = 0; bus.load = 0; bus.preset_min = 0; bus.preset_sec = 0;
    bus.start_stop = 0; bus.clear = 0;
    reset = 1'b1;
    model_reset();
    @(negedge clk_in);
    @(negedge clk_in);
    check_outputs("reset");
    reset = 1'b0;

    // 01:05 counting down through the minute boundary
    step("ld0105", 0, 1, 8'h01, 8'h05, 0, 0);
    step("start1", 0, 0, 8'h00, 8'h00, 1, 0);
    ticks("run1", 6);
    chk("t1_count", 32'({bus.time_min, bus.time_sec}), 32'h0059);
    chk("t1_run_en", 32'(bus.run_en), 32'd1);
    step("clr1", 0, 0, 8'h00, 8'h00, 0, 1);

    // 00:02 into ALARM, then the alarm times out on its own
    step("ld0002", 0, 1, 8'h00, 8'h02, 0, 0);
    step("start2", 0, 0, 8'h00, 8'h00, 1, 0);
    ticks("run2", 2);
    chk("t2_alarm", 32'({bus.state_o, bus.alarm}), 32'({2'd3, 1'b1}));
    ticks("alarm2", AT - 1);
    chk("t2_still_alarm", 32'(bus.state_o), 32'd3);
    ticks("alarm2_end", 1);
    chk("t2_idle", 32'(bus.state_o), 32'd0);

    // tick and start_stop together: decrement applied, pause taken
    step("ld0010", 0, 1, 8'h00, 8'h10, 0, 0);
    step("start3", 0, 0, 8'h00, 8'h00, 1, 0);
    step("tick_ss", 1, 0, 8'h00, 8'h00, 1, 0);
    chk("t3_pause", 32'({bus.time_min, bus.time_sec, bus.state_o, bus.run_en}),
        32'({16'h0009, 2'd2, 1'b0}));
    ticks("pause3", 3);
    chk("t3_hold", 32'({bus.time_min, bus.time_sec}), 32'h0009);
    step("clr3", 0, 0, 8'h00, 8'h00, 0, 1);

    // rejected preset, then start at 00:00 ignored
    step("ld0007", 0, 1, 8'h00, 8'h07, 0, 0);
    step("ld_bad", 0, 1, 8'h00, 8'h6A, 0, 0);
    chk("t4_lerr", 32'({bus.load_err, bus.time_min, bus.time_sec}), 32'({1'b1, 16'h0007}));
    step("after_bad", 0, 0, 8'h00, 8'h00, 0, 0);
    chk("t4_lerr_once", 32'(bus.load_err), 32'd0);
    step("clr4", 0, 0, 8'h00, 8'h00, 0, 1);
    step("start_zero", 0, 0, 8'h00, 8'h00, 1, 0);
    chk("t4_idle", 32'(bus.state_o), 32'd0);

    // minute-tens borrow, then clear beats a tick
    step("ld1000", 0, 1, 8'h10, 8'h00, 0, 0);
    step("start5", 0, 0, 8'h00, 8'h00, 1, 0);
    ticks("run5", 1);
    chk("t5_0959", 32'({bus.time_min, bus.time_sec}), 32'h0959);
    step("clr_tick", 1, 0, 8'h00, 8'h00, 0, 1);
    chk("t5_clear", 32'({bus.time_min, bus.time_sec, bus.state_o}), 32'({16'h0000, 2'd0}));

    // asynchronous reset between edges, mid-RUN
    step("ld0500", 0, 1, 8'h05, 8'h00, 0, 0);
    step("start6", 0, 0, 8'h00, 8'h00, 1, 0);
    ticks("run6", 2);
    @(posedge clk_in);
    model_edge(0, 0, 8'h00, 8'h00, 0, 0);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk_in);
    reset = 1'b0;

    // random events
    for (int i = 0; i < 2500; i++) begin
      bit tk, ld, ss, cl;
      logic [7:0] pm, ps;
      int r;
      tk = ($urandom_range(0, 9) < 3);
      r  = $urandom_range(0, 99);
      ld = (r < 5);
      ss = (r >= 5 && r < 14);
      cl = ($urandom_range(0, 99) < 2);
      if ($urandom_range(0, 3) == 0) begin
        pm = 8'($urandom);
        ps = 8'($urandom);
      end else begin
        int mm, sc;
        mm = $urandom_range(0, 2);
        sc = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 59);
        pm = 8'((mm / 10) * 16 + mm % 10);
        ps = 8'((sc / 10) * 16 + sc % 10);
      end
      step("rand", tk, ld, pm, ps, ss, cl);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
